// File: rtl/asic_daq_responder.sv
// asic_daq_responder: emulates a DAQ front-end chip. It runs an acquisition
// window, reports chip-full on CHIPSATB, and serves a readout burst on request.
// Optional feature macro: ASIC_DAQ_TRIG_EN enables trigger counting and the
// trigger-depth full condition. With the macro undefined, ExternalTrigger and
// TrigDepth are ignored and the readout header is 16'hA500.
module asic_daq_responder (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        RESET_B,
  input  logic        START_ACQ,
  input  logic        StartReadout,
  input  logic        ExternalTrigger,
  input  logic [15:0] FullCount,
  input  logic [7:0]  TrigDepth,
  input  logic [7:0]  SatbHoldTime,
  input  logic [7:0]  ReadoutLength,
  output logic        CHIPSATB,
  output logic        EndReadout,
  output logic [15:0] DataOut,
  output logic        DataValid,
  output logic [7:0]  AcqIndex
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam logic [BYTE_W-1:0] HDR_TAG  = 8'hA5;
  localparam logic [BYTE_W-1:0] BYTE_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACQ     = 3'd1,
    S_FULL    = 3'd2,
    S_WAIT_RO = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [CNT_W-1:0]    r_acq_cnt,   w_acq_cnt_nxt;
  logic [BYTE_W-1:0]   r_trig_cnt,  w_trig_cnt_nxt;
  logic [BYTE_W-1:0]   r_hold_cnt,  w_hold_cnt_nxt;
  logic [BYTE_W-1:0]   r_word_idx,  w_word_idx_nxt;
  logic [BYTE_W-1:0]   r_acq_index, w_acq_index_nxt;
  logic [WORD_W-1:0]   r_dout,      w_dout_nxt;
  logic                r_satb_n,    w_satb_n_nxt;
  logic                r_end_ro,    w_end_ro_nxt;
  logic                r_dvalid,    w_dvalid_nxt;
  logic                r_trig_prev;

  logic                w_time_full;
  logic                w_trig_full;
  logic                w_trig_rise;
  logic [BYTE_W-1:0]   w_hold_len;

  // Time-based full: the IDLE sample is edge 0, so AcqCnt reaches FullCount-1 on edge FullCount
  assign w_time_full = (FullCount != 16'd0) && (r_acq_cnt == CNT_W'(FullCount - 16'd1));

  // A zero hold time still produces a one-cycle CHIPSATB pulse
  assign w_hold_len = (SatbHoldTime == 8'd0) ? 8'd1 : SatbHoldTime;

`ifdef ASIC_DAQ_TRIG_EN
  assign w_trig_rise = ExternalTrigger & ~r_trig_prev;
  assign w_trig_full = (TrigDepth != 8'd0) && (r_trig_cnt >= TrigDepth);
`else
  logic w_unused_trig;
  assign w_trig_rise   = 1'b0;
  assign w_trig_full   = 1'b0;
  assign w_unused_trig = ^{TrigDepth, r_trig_prev};
`endif

  // Trigger edge-detect history, tracked every cycle
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) r_trig_prev <= 1'b0;
    else          r_trig_prev <= ExternalTrigger;
  end

  // State and output registers
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_acq_cnt   <= '0;
      r_trig_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_word_idx  <= '0;
      r_acq_index <= '0;
      r_dout      <= '0;
      r_satb_n    <= 1'b1;
      r_end_ro    <= 1'b0;
      r_dvalid    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acq_cnt   <= w_acq_cnt_nxt;
      r_trig_cnt  <= w_trig_cnt_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_acq_index <= w_acq_index_nxt;
      r_dout      <= w_dout_nxt;
      r_satb_n    <= w_satb_n_nxt;
      r_end_ro    <= w_end_ro_nxt;
      r_dvalid    <= w_dvalid_nxt;
    end
  end

  // Next-state and next-output logic; RESET_B overrides everything except AcqIndex and DataOut
  always_comb begin
    w_state_nxt     = r_state;
    w_acq_cnt_nxt   = r_acq_cnt;
    w_trig_cnt_nxt  = r_trig_cnt;
    w_hold_cnt_nxt  = r_hold_cnt;
    w_word_idx_nxt  = r_word_idx;
    w_acq_index_nxt = r_acq_index;
    w_dout_nxt      = r_dout;
    w_satb_n_nxt    = r_satb_n;
    w_end_ro_nxt    = 1'b0;
    w_dvalid_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_satb_n_nxt = 1'b1;
        if (START_ACQ) begin
          w_state_nxt    = S_ACQ;
          w_acq_cnt_nxt  = '0;
          w_trig_cnt_nxt = '0;
        end
      end

      S_ACQ: begin
        if (w_trig_rise && (r_trig_cnt != BYTE_MAX)) begin
          w_trig_cnt_nxt = BYTE_W'(r_trig_cnt + 8'd1);
        end
        if (!START_ACQ) begin
          w_state_nxt = S_WAIT_RO;
        end else begin
          w_acq_cnt_nxt = CNT_W'(r_acq_cnt + 16'd1);
          if (w_time_full || w_trig_full) begin
            w_state_nxt    = S_FULL;
            w_satb_n_nxt   = 1'b0;
            w_hold_cnt_nxt = '0;
          end
        end
      end

      S_FULL: begin
        if (r_hold_cnt == BYTE_W'(w_hold_len - 8'd1)) begin
          w_satb_n_nxt = 1'b1;
          w_state_nxt  = S_WAIT_RO;
        end else begin
          w_hold_cnt_nxt = BYTE_W'(r_hold_cnt + 8'd1);
        end
      end

      S_WAIT_RO: begin
        if (StartReadout) begin
          w_state_nxt    = S_READOUT;
          w_word_idx_nxt = '0;
        end
      end

      S_READOUT: begin
        if (r_word_idx < ReadoutLength) begin
          w_dvalid_nxt   = 1'b1;
          w_dout_nxt     = (r_word_idx == 8'd0) ? {HDR_TAG, r_trig_cnt}
                                                : {r_acq_index, r_word_idx};
          w_word_idx_nxt = BYTE_W'(r_word_idx + 8'd1);
        end else begin
          w_end_ro_nxt    = 1'b1;
          w_acq_index_nxt = BYTE_W'(r_acq_index + 8'd1);
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (!RESET_B) begin
      w_state_nxt     = S_IDLE;
      w_satb_n_nxt    = 1'b1;
      w_dvalid_nxt    = 1'b0;
      w_end_ro_nxt    = 1'b0;
      w_acq_cnt_nxt   = '0;
      w_trig_cnt_nxt  = '0;
      w_hold_cnt_nxt  = '0;
      w_word_idx_nxt  = '0;
      w_dout_nxt      = r_dout;
      w_acq_index_nxt = r_acq_index;
    end
  end

  assign CHIPSATB   = r_satb_n;
  assign EndReadout = r_end_ro;
  assign DataOut    = r_dout;
  assign DataValid  = r_dvalid;
  assign AcqIndex   = r_acq_index;

endmodule

// File: tb/tb_asic_daq_responder.sv
// Randomized self-checking bench for asic_daq_responder; expectations come
// from edge arithmetic on the stimulus, not from the DUT.
module tb_asic_daq_responder;

  logic        Clk = 1'b0;
  logic        reset_n;
  logic        RESET_B;
  logic        START_ACQ;
  logic        StartReadout;
  logic        ExternalTrigger;
  logic [15:0] FullCount;
  logic [7:0]  TrigDepth;
  logic [7:0]  SatbHoldTime;
  logic [7:0]  ReadoutLength;
  logic        CHIPSATB;
  logic        EndReadout;
  logic [15:0] DataOut;
  logic        DataValid;
  logic [7:0]  AcqIndex;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_idx;
  logic [15:0] exp_dout;
  logic [7:0]  acq_trig;

  asic_daq_responder dut (
    .Clk             (Clk),
    .reset_n         (reset_n),
    .RESET_B         (RESET_B),
    .START_ACQ       (START_ACQ),
    .StartReadout    (StartReadout),
    .ExternalTrigger (ExternalTrigger),
    .FullCount       (FullCount),
    .TrigDepth       (TrigDepth),
    .SatbHoldTime    (SatbHoldTime),
    .ReadoutLength   (ReadoutLength),
    .CHIPSATB        (CHIPSATB),
    .EndReadout      (EndReadout),
    .DataOut         (DataOut),
    .DataValid       (DataValid),
    .AcqIndex        (AcqIndex)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // One active edge, then settle so registered outputs can be sampled
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Time-full acquisition: edge 0 is the IDLE sample, CHIPSATB low on edges [f, f+hold)
  task automatic do_time_acq(input int f, input int h, input bit rnd_trig);
    int he;
    int rises;
    bit t_prev;
    bit t_cur;
    FullCount       = 16'(f);
    SatbHoldTime    = 8'(h);
    TrigDepth       = 8'd0;
    ExternalTrigger = 1'b0;
    START_ACQ       = 1'b1;
    step();
    chk("satb_edge0", 32'(CHIPSATB), 32'(1));
    he     = (h == 0) ? 1 : h;
    rises  = 0;
    t_prev = 1'b0;
    for (int n = 1; n <= f + he + 3; n++) begin
      t_cur = rnd_trig ? 1'($urandom_range(0, 1)) : 1'b0;
      ExternalTrigger = t_cur;
      if (n <= f && t_cur && !t_prev) rises++;
      t_prev = t_cur;
      step();
      chk("satb_time", 32'(CHIPSATB), 32'((n >= f && n < f + he) ? 1'b0 : 1'b1));
      chk("dv_acq", 32'(DataValid), 32'(0));
    end
    START_ACQ       = 1'b0;
    ExternalTrigger = 1'b0;
`ifdef ASIC_DAQ_TRIG_EN
    acq_trig = 8'((rises > 255) ? 255 : rises);
`else
    acq_trig = 8'd0;
`endif
  endtask

  // Acquisition closed by START_ACQ before full; a stray StartReadout in ACQ must be ignored
  task automatic do_short_acq(input int f, input int n_hi);
    FullCount       = 16'(f);
    ExternalTrigger = 1'b0;
    START_ACQ       = 1'b1;
    step();
    for (int n = 1; n < n_hi; n++) begin
      StartReadout = (n == 1);
      step();
      StartReadout = 1'b0;
      chk("satb_short", 32'(CHIPSATB), 32'(1));
      chk("dv_short", 32'(DataValid), 32'(0));
    end
    START_ACQ = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("satb_wait", 32'(CHIPSATB), 32'(1));
      chk("dv_wait", 32'(DataValid), 32'(0));
      chk("end_wait", 32'(EndReadout), 32'(0));
    end
    acq_trig = 8'd0;
  endtask

`ifdef ASIC_DAQ_TRIG_EN
  // Trigger-full: 4-cycle pulses every 7 edges from edge 2; full on the edge after the last rise
  task automatic do_trig_acq(input int depth, input int h);
    int he;
    int n_r;
    FullCount       = 16'd0;
    TrigDepth       = 8'(depth);
    SatbHoldTime    = 8'(h);
    ExternalTrigger = 1'b0;
    START_ACQ       = 1'b1;
    step();
    he  = (h == 0) ? 1 : h;
    n_r = 2 + 7 * (depth - 1);
    for (int n = 1; n <= n_r + 1 + he + 3; n++) begin
      ExternalTrigger = (n >= 2) && (((n - 2) / 7) < depth) && (((n - 2) % 7) < 4);
      step();
      chk("satb_trig", 32'(CHIPSATB),
          32'((n >= n_r + 1 && n < n_r + 1 + he) ? 1'b0 : 1'b1));
    end
    START_ACQ       = 1'b0;
    ExternalTrigger = 1'b0;
    TrigDepth       = 8'd0;
    acq_trig        = 8'(depth);
  endtask
`endif

  // Readout burst from WAIT_RO: words on edges E+1..E+len, EndReadout on E+len+1
  task automatic do_readout(input int len, input logic [7:0] trig);
    logic [15:0] w;
    logic [7:0]  k8;
    ReadoutLength = 8'(len);
    StartReadout  = 1'b1;
    step();
    StartReadout = 1'b0;
    chk("dv_start", 32'(DataValid), 32'(0));
    for (int k = 0; k < len; k++) begin
      k8 = 8'(k);
      w  = (k == 0) ? {8'hA5, trig} : {exp_idx, k8};
      step();
      chk("dv_word", 32'(DataValid), 32'(1));
      chk("data_word", 32'(DataOut), 32'(w));
      chk("end_early", 32'(EndReadout), 32'(0));
      exp_dout = w;
    end
    step();
    exp_idx = 8'(exp_idx + 8'd1);
    chk("end_pulse", 32'(EndReadout), 32'(1));
    chk("dv_end", 32'(DataValid), 32'(0));
    chk("acq_index", 32'(AcqIndex), 32'(exp_idx));
    chk("data_hold", 32'(DataOut), 32'(exp_dout));
    step();
    chk("end_once", 32'(EndReadout), 32'(0));
    chk("dv_idle", 32'(DataValid), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nh;
    int f;
    reset_n         = 1'b0;
    RESET_B         = 1'b1;
    START_ACQ       = 1'b0;
    StartReadout    = 1'b0;
    ExternalTrigger = 1'b0;
    FullCount       = 16'd0;
    TrigDepth       = 8'd0;
    SatbHoldTime    = 8'd0;
    ReadoutLength   = 8'd0;
    exp_idx         = 8'd0;
    exp_dout        = 16'd0;
    acq_trig        = 8'd0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_satb", 32'(CHIPSATB), 32'(1));
    chk("rst_end", 32'(EndReadout), 32'(0));
    chk("rst_dv", 32'(DataValid), 32'(0));
    chk("rst_dout", 32'(DataOut), 32'(0));
    chk("rst_idx", 32'(AcqIndex), 32'(0));
    reset_n = 1'b1;
    step();

    // Early stop with FullCount far away, then zero-length readout
    do_short_acq(1000, 200);
    do_readout(0, acq_trig);

    // Long time-full window with random trigger activity
    do_time_acq(60, 11, 1'b1);
    do_readout(int'($urandom_range(1, 8)), acq_trig);

    // AcqIndex is 2 here: header, 0201, 0202, 0203
    do_time_acq(int'($urandom_range(1, 30)), int'($urandom_range(0, 5)), 1'b0);
    do_readout(4, acq_trig);

    // Minimum full count and zero hold time
    do_time_acq(1, 0, 1'b0);
    do_readout(1, acq_trig);

`ifdef ASIC_DAQ_TRIG_EN
    do_trig_acq(3, 2);
    do_readout(3, acq_trig);
    chk("hdr_a503", 32'({8'hA5, acq_trig}), 32'(16'hA503));
`endif

    for (int it = 0; it < 10; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          do_time_acq(int'($urandom_range(1, 50)), int'($urandom_range(0, 12)), 1'b1);
          do_readout(int'($urandom_range(0, 10)), acq_trig);
        end
        1: begin
          nh = int'($urandom_range(1, 40));
          f  = ($urandom_range(0, 1) == 0) ? 0 : nh + int'($urandom_range(0, 20));
          do_short_acq(f, nh);
          do_readout(int'($urandom_range(0, 10)), acq_trig);
        end
        default: begin
`ifdef ASIC_DAQ_TRIG_EN
          do_trig_acq(int'($urandom_range(1, 4)), int'($urandom_range(0, 6)));
`else
          do_time_acq(int'($urandom_range(1, 20)), int'($urandom_range(0, 6)), 1'b1);
`endif
          do_readout(int'($urandom_range(0, 6)), acq_trig);
        end
      endcase
    end

    // RESET_B mid-readout: drop DataValid, no EndReadout, AcqIndex and DataOut kept
    do_time_acq(5, 2, 1'b0);
    ReadoutLength = 8'd6;
    StartReadout  = 1'b1;
    step();
    StartReadout = 1'b0;
    step();
    step();
    chk("rb_word1", 32'(DataOut), 32'({exp_idx, 8'd1}));
    exp_dout = {exp_idx, 8'd1};
    RESET_B  = 1'b0;
    step();
    RESET_B = 1'b1;
    chk("rb_dv", 32'(DataValid), 32'(0));
    chk("rb_end", 32'(EndReadout), 32'(0));
    chk("rb_idx", 32'(AcqIndex), 32'(exp_idx));
    chk("rb_dout", 32'(DataOut), 32'(exp_dout));
    for (int n = 0; n < 8; n++) begin
      step();
      chk("rb_end_after", 32'(EndReadout), 32'(0));
      chk("rb_dv_after", 32'(DataValid), 32'(0));
    end
    // Back in IDLE: a fresh acquisition counts from edge 0 again
    do_time_acq(3, 1, 1'b0);
    do_readout(2, acq_trig);

    // AcqIndex wraps through 255 -> 0
    for (int it = 0; it < 256; it++) begin
      do_time_acq(1, 1, 1'b0);
      do_readout(0, acq_trig);
    end
    chk("idx_wrap", 32'(AcqIndex), 32'(exp_idx));

    // Asynchronous reset between edges clears AcqIndex immediately
    do_time_acq(2, 1, 1'b0);
    do_readout(1, acq_trig);
    reset_n = 1'b0;
    #2;
    chk("async_idx", 32'(AcqIndex), 32'(0));
    chk("async_dout", 32'(DataOut), 32'(0));
    chk("async_satb", 32'(CHIPSATB), 32'(1));
    reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
